flyback_pwm_core: RTL and testbench
===================================

Name: flyback_pwm_core

Overview:
- Gate-drive PWM generator for the flyback primary switch.
- Consumes the period, duty, enable and fault-clear values written over AXI4-Lite into the system_controller register bank; sits directly downstream of that slave.
- Provides shadowed (glitch-free) period/duty updates, soft-start ramp, minimum off-time clamp, and latched fault shutdown.
- Reports status bits back for readback through the register bank.

Parameters:
- CNT_W, 16, width of period/duty/counter.
- SS_STEP, 16'd8, duty increment per PWM period during soft start.
- MIN_OFF, 16'd4, minimum gate-low cycles per period (duty clamp).
- MIN_PERIOD, 16'd8, smallest accepted period; smaller values rejected.

Ports:
- ACLK  in  1  system clock.
- ARESET  in  1  asynchronous active-high reset.
- enable  in  1  run request (level, register bit).
- period_in  in  CNT_W  requested period in ACLK cycles.
- duty_in  in  CNT_W  requested gate-high cycles.
- cfg_update  in  1  one-cycle pulse: capture period_in/duty_in into pending.
- fault_in  in  1  asynchronous overcurrent/OVP comparator, active-high.
- fault_clr  in  1  one-cycle pulse: clear latched fault.
- gate  out  1  registered switch drive.
- cycle_start  out  1  one-cycle pulse on counter wrap to 0.
- state_o  out  2  00 IDLE, 01 SOFTSTART, 10 RUN, 11 FAULT.
- fault_latched  out  1  sticky fault flag.
- cfg_err  out  1  sticky: last cfg_update had period_in < MIN_PERIOD; cleared by next valid cfg_update.

Behaviour:
- Interface: one clock, ACLK. ARESET is asynchronous and active-high; every flop clears on its assertion.
- Reset values:
  - gate=0, cycle_start=0, state_o=IDLE, fault_latched=0, cfg_err=0.
  - counter=0, duty_ss=0.
  - pending and active registers: period=MIN_PERIOD, duty=0.
- Fault input: fault_in passes through a 2-FF synchroniser; fault_s is its output. Fault response latency is 3 ACLK edges from fault_in rising to gate low.
- cfg_update handling:
  - If period_in >= MIN_PERIOD: pending <= {period_in, duty_in} and cfg_err <= 0.
  - Otherwise: pending is unchanged and cfg_err <= 1.
- Active registers load from pending only at the terminal count (counter == period_act-1), or on the IDLE->SOFTSTART transition. The period and duty in use never change mid-period.
- cfg_update coincident with the terminal count: the old pending value is loaded; the new value lands in pending and takes effect one period later.
- Duty clamp: duty_tgt = min(duty_act, period_act - MIN_OFF), computed at CNT_W width with no underflow (period_act >= MIN_PERIOD > MIN_OFF).
- Counter: in SOFTSTART/RUN it counts 0..period_act-1 and wraps. cycle_start is high in the cycle the counter equals 0.
- Gate:
  - gate <= (counter < duty_cur) in SOFTSTART/RUN, registered, so gate lags the counter by 1 cycle.
  - duty_cur = duty_ss in SOFTSTART, duty_tgt in RUN.
- State machine (priority: fault > enable):
  - IDLE: gate=0, counter=0. Goes to SOFTSTART when enable=1 and fault_latched=0; on entry duty_ss=0, then at each terminal count duty_ss <= min(duty_ss+SS_STEP, duty_tgt), saturating with no wrap.
  - SOFTSTART: goes to RUN at the terminal count where duty_ss has reached duty_tgt.
  - SOFTSTART/RUN: enable=0 -> IDLE next cycle, gate=0 next cycle, counter=0, no period completion.
  - Any state: fault_s=1 -> FAULT; fault_latched<=1; gate<=0.
  - FAULT: gate held 0. On fault_clr while fault_s=0: fault_latched<=0 and go to IDLE. fault_clr while fault_s=1 is ignored.
  - From IDLE after a fault clear, re-entry requires enable=1. If enable stayed high, soft start restarts from 0.
- duty_in=0: gate stays low the whole period.
- duty_in >= period: clamped to period-MIN_OFF.
- ARESET mid-period: gate falls asynchronously, with no glitch high.

Test Plan:
- Reset and defaults: ARESET high 5 cycles then low, enable=0 -> gate=0, state_o=00, all flags 0 for 50 cycles.
- Soft start: cfg_update period=100, duty=40, SS_STEP=8, enable=1 -> gate-high widths per period are 0,8,16,24,32,40, then state_o=10 and steady 40/100. cycle_start fires every 100 cycles.
- Shadow update: in RUN, cfg_update period=60, duty=30 at counter=50 -> current period completes at 100/40; next period is 60/30; no truncated pulse.
- Clamp and reject: duty=200, period=100 -> high 96 cycles. cfg_update period=5 -> cfg_err=1, waveform unchanged. Next valid update clears cfg_err.
- Fault: fault_in pulse at counter=10 while gate high -> gate low within 3 edges, state_o=11, fault_latched=1.
  - fault_clr while fault_in high -> no change.
  - Drop fault_in, then fault_clr -> IDLE, then soft start restarts from duty 0.
- Enable drop and reset mid-op: enable=0 at counter=20 -> gate=0 next cycle, state_o=00. ARESET asserted mid-pulse -> gate low immediately, state_o=00.

Source files
------------

// File: rtl/flyback_pwm_core.sv
// Flyback primary-switch PWM: shadowed period/duty, soft-start ramp,
// minimum off-time clamp and latched fault shutdown.
module flyback_pwm_core #(
  parameter int              CNT_W      = 16,
  parameter logic [CNT_W-1:0] SS_STEP    = 16'd8,
  parameter logic [CNT_W-1:0] MIN_OFF    = 16'd4,
  parameter logic [CNT_W-1:0] MIN_PERIOD = 16'd8
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             enable,
  input  logic [CNT_W-1:0] period_in,
  input  logic [CNT_W-1:0] duty_in,
  input  logic             cfg_update,
  input  logic             fault_in,
  input  logic             fault_clr,
  output logic             gate,
  output logic             cycle_start,
  output logic [1:0]       state_o,
  output logic             fault_latched,
  output logic             cfg_err
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_SS    = 2'b01;
  localparam logic [1:0] S_RUN   = 2'b10;
  localparam logic [1:0] S_FAULT = 2'b11;

  logic [1:0]       state, state_nx;
  logic             fault_meta, fault_s;
  logic [CNT_W-1:0] counter, duty_ss;
  logic [CNT_W-1:0] pend_period, pend_duty, act_period, act_duty;
  logic [CNT_W-1:0] off_limit, duty_tgt, duty_cur;
  logic [CNT_W:0]   ss_sum;
  logic             running, term, stay, load_act;

  assign running   = (state == S_SS) || (state == S_RUN);
  assign term      = running && (counter == act_period - CNT_W'(1));
  // act_period >= MIN_PERIOD > MIN_OFF, so this never underflows
  assign off_limit = act_period - MIN_OFF;
  assign duty_tgt  = (act_duty < off_limit) ? act_duty : off_limit;
  assign duty_cur  = (state == S_SS) ? duty_ss : duty_tgt;
  assign ss_sum    = {1'b0, duty_ss} + {1'b0, SS_STEP};
  assign stay      = running && ((state_nx == S_SS) || (state_nx == S_RUN));
  assign load_act  = ((state == S_IDLE) && (state_nx == S_SS)) || (term && stay);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (fault_s) begin
      state_nx = S_FAULT;
    end else begin
      case (state)
        S_IDLE:  if (enable && !fault_latched) state_nx = S_SS;
        S_SS: begin
          if (!enable)                          state_nx = S_IDLE;
          else if (term && duty_ss >= duty_tgt) state_nx = S_RUN;
        end
        S_RUN:   if (!enable)  state_nx = S_IDLE;
        default: if (fault_clr) state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    state_o     = state;
    cycle_start = running && (counter == '0);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      fault_meta    <= 1'b0;
      fault_s       <= 1'b0;
      fault_latched <= 1'b0;
      cfg_err       <= 1'b0;
      pend_period   <= MIN_PERIOD;
      pend_duty     <= '0;
      act_period    <= MIN_PERIOD;
      act_duty      <= '0;
      counter       <= '0;
      duty_ss       <= '0;
      gate          <= 1'b0;
    end else begin
      fault_meta <= fault_in;
      fault_s    <= fault_meta;

      if (fault_s)                          fault_latched <= 1'b1;
      else if (state == S_FAULT && fault_clr) fault_latched <= 1'b0;

      if (cfg_update) begin
        if (period_in >= MIN_PERIOD) begin
          pend_period <= period_in;
          pend_duty   <= duty_in;
          cfg_err     <= 1'b0;
        end else begin
          cfg_err     <= 1'b1;
        end
      end

      // Pending moves to active only at a period boundary or on start-up
      if (load_act) begin
        act_period <= pend_period;
        act_duty   <= pend_duty;
      end

      if (stay) counter <= term ? '0 : counter + CNT_W'(1);
      else      counter <= '0;

      if (state == S_IDLE)
        duty_ss <= '0;
      else if (state == S_SS && term && stay)
        duty_ss <= (ss_sum >= {1'b0, duty_tgt}) ? duty_tgt : ss_sum[CNT_W-1:0];

      gate <= stay && (counter < duty_cur);
    end
  end

endmodule

// File: tb/tb_flyback_pwm_core.sv
// Directed bench for flyback_pwm_core: measures gate-high width and period
// length between cycle_start pulses and checks state/flag responses.
module tb_flyback_pwm_core;
  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        enable = 1'b0;
  logic        cfg_update = 1'b0;
  logic        fault_in = 1'b0;
  logic        fault_clr = 1'b0;
  logic [15:0] period_in = '0;
  logic [15:0] duty_in = '0;
  logic        gate, cycle_start, fault_latched, cfg_err;
  logic [1:0]  state_o;

  int vectors = 0;
  int miscompares = 0;
  int ss_w[6] = '{0, 8, 16, 24, 32, 40};

  flyback_pwm_core dut (
    .ACLK(ACLK), .ARESET(ARESET), .enable(enable),
    .period_in(period_in), .duty_in(duty_in), .cfg_update(cfg_update),
    .fault_in(fault_in), .fault_clr(fault_clr), .gate(gate),
    .cycle_start(cycle_start), .state_o(state_o),
    .fault_latched(fault_latched), .cfg_err(cfg_err)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic cfg_pulse(input logic [15:0] p, input logic [15:0] d);
    @(posedge ACLK); #1;
    period_in = p; duty_in = d; cfg_update = 1'b1;
    @(posedge ACLK); #1;
    cfg_update = 1'b0;
  endtask

  task automatic wait_cs();
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge ACLK);
      seen = cycle_start;
    end
    if (!seen) check("cycle_start_timeout", 0, 1);
  endtask

  // Entered on a negedge with cycle_start high; returns on the next one.
  task automatic measure(input string tag, input int exp_hi, input int exp_len);
    int h, l;
    bit done = 1'b0;
    h = int'(gate);
    l = 1;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge ACLK);
      if (cycle_start) done = 1'b1;
      else begin
        h += int'(gate);
        l++;
      end
    end
    if (!done) check({tag, "_timeout"}, 0, 1);
    check({tag, "_high"}, h, exp_hi);
    check({tag, "_len"}, l, exp_len);
  endtask

  initial begin
    repeat (5) @(posedge ACLK);
    #1 ARESET = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      check("idle_outputs", int'({gate, cycle_start, state_o, fault_latched, cfg_err}), 0);
    end

    // Soft start to 40/100
    cfg_pulse(16'd100, 16'd40);
    enable = 1'b1;
    wait_cs();
    for (int i = 0; i < 6; i++) measure($sformatf("ss%0d", i), ss_w[i], 100);
    check("run_state", int'(state_o), 2);
    measure("run", 40, 100);

    // Shadow update landing at counter=50
    fork
      begin
        repeat (49) @(posedge ACLK);
        cfg_pulse(16'd60, 16'd30);
      end
    join_none
    measure("shadow_old", 40, 100);
    measure("shadow_new", 30, 60);

    // Duty clamp, rejected period, then valid update
    fork cfg_pulse(16'd100, 16'd200); join_none
    measure("pre_clamp", 30, 60);
    measure("clamp", 96, 100);
    fork cfg_pulse(16'd5, 16'd10); join_none
    measure("reject_same", 96, 100);
    check("cfg_err_set", int'(cfg_err), 1);
    measure("reject_hold", 96, 100);
    fork cfg_pulse(16'd100, 16'd40); join_none
    measure("valid_cur", 96, 100);
    check("cfg_err_clr", int'(cfg_err), 0);
    measure("valid_new", 40, 100);

    // Fault at counter=10 with gate high
    repeat (10) @(posedge ACLK);
    #1 check("gate_pre_fault", int'(gate), 1);
    fault_in = 1'b1;
    repeat (2) @(posedge ACLK);
    #1 check("gate_edge2", int'(gate), 1);
    @(posedge ACLK);
    #1 check("gate_edge3", int'(gate), 0);
    check("fault_state", int'(state_o), 3);
    check("fault_latched", int'(fault_latched), 1);
    fault_clr = 1'b1;
    @(posedge ACLK);
    #1 fault_clr = 1'b0;
    check("clr_ignored_state", int'(state_o), 3);
    check("clr_ignored_flag", int'(fault_latched), 1);
    fault_in = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 check("fault_hold", int'(state_o), 3);
    fault_clr = 1'b1;
    @(posedge ACLK);
    #1 fault_clr = 1'b0;
    check("clr_state", int'(state_o), 0);
    check("clr_flag", int'(fault_latched), 0);
    wait_cs();
    for (int i = 0; i < 6; i++) measure($sformatf("restart%0d", i), ss_w[i], 100);
    check("restart_run", int'(state_o), 2);

    // Enable drop at counter=20
    repeat (20) @(posedge ACLK);
    #1 check("gate_pre_drop", int'(gate), 1);
    enable = 1'b0;
    @(posedge ACLK);
    #1 check("drop_gate", int'(gate), 0);
    check("drop_state", int'(state_o), 0);
    check("drop_cs", int'(cycle_start), 0);

    // Re-run, then asynchronous reset mid-pulse
    enable = 1'b1;
    wait_cs();
    for (int i = 0; i < 6; i++) measure($sformatf("rerun%0d", i), ss_w[i], 100);
    repeat (20) @(posedge ACLK);
    #1 check("gate_pre_rst", int'(gate), 1);
    #2 ARESET = 1'b1;
    #1 check("rst_gate", int'(gate), 0);
    check("rst_state", int'(state_o), 0);
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    wait_cs();
    measure("post_reset", 0, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
